// File: rtl/ram_arbiter.sv
// Two-port (A fetch / B data) arbiter in front of a single synchronous-read RAM.
// Define RAM_ARB_RR_EN for round-robin contention; otherwise port A has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                id_q;          // 0 = port A, 1 = port B
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                grant_b;
    logic                start;

    assign start = (state_q == IDLE) && (a_req || b_req);

`ifdef RAM_ARB_RR_EN
    logic last_b_q;

    // On contention the port that did not win last time is served.
    assign grant_b = b_req && (!a_req || !last_b_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (start) begin
            last_b_q <= grant_b;
        end
    end
`else
    assign grant_b = b_req && !a_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_req || b_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RESP && !we_q) begin
                if (id_q) b_rdata_q <= ram_rdata;
                else      a_rdata_q <= ram_rdata;
            end
        end
    end

    // Request fields are only observed while in ACCESS/RESP, so they need no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            id_q    <= grant_b;
            we_q    <= grant_b ? b_we    : a_we;
            addr_q  <= grant_b ? b_addr  : a_addr;
            wdata_q <= grant_b ? b_wdata : a_wdata;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ram_we    = (state_q == ACCESS) && we_q;
    assign ram_re    = (state_q == ACCESS) && !we_q;
    assign ram_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign ram_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign a_ack     = (state_q == RESP) && !id_q;
    assign b_ack     = (state_q == RESP) && id_q;

    // The RAM's registered output is live during RESP; pass it through, then hold it.
    assign a_rdata = (a_ack && !we_q) ? ram_rdata : a_rdata_q;
    assign b_rdata = (b_ack && !we_q) ? ram_rdata : b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized phase
// against a transaction-level model (arbitration rule, memory image, held rdata).
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack, ram_we, ram_re, busy;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int compared = 0;
    int mismatched = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM attached to the arbiter.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ram_q = '0;
    logic          mem_init = 1'b0;
    assign ram_rdata = ram_q;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        if (ram_re) ram_q <= ram_mem[ram_addr];
    end

    // Reference model state.
    logic [DW-1:0] mdl_mem [256];
    bit            mdl_last_b;
    logic [DW-1:0] mdl_a_rd, mdl_b_rd;
    bit            pv [2];
    bit            pwe [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pwd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        a_req = pv[0]; a_we = pwe[0]; a_addr = paddr[0]; a_wdata = pwd[0];
        b_req = pv[1]; b_we = pwe[1]; b_addr = paddr[1]; b_wdata = pwd[1];
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        pv[p] = 1'b1; pwe[p] = we; paddr[p] = addr; pwd[p] = wd;
    endtask

    function automatic int pick();
        if (pv[0] && pv[1]) begin
`ifdef RAM_ARB_RR_EN
            return mdl_last_b ? 0 : 1;
`else
            return 0;
`endif
        end
        return pv[1] ? 1 : 0;
    endfunction

    // Runs one transaction from IDLE (called just after a rising edge) and
    // returns just after the edge that brings the arbiter back to IDLE.
    task automatic run_grant();
        int w;
        w = pick();
        drive();
        @(posedge clk); @(negedge clk);
        chk("acc_busy",  32'(busy), 32'd1);
        chk("acc_we",    32'(ram_we), 32'(pwe[w]));
        chk("acc_re",    32'(ram_re), 32'(!pwe[w]));
        chk("acc_addr",  32'(ram_addr), 32'(paddr[w]));
        chk("acc_wdata", 32'(ram_wdata), 32'(pwd[w]));
        chk("acc_noack", 32'({a_ack, b_ack}), 32'd0);
        @(posedge clk); @(negedge clk);
        if (pwe[w]) mdl_mem[paddr[w]] = pwd[w];
        else if (w == 0) mdl_a_rd = mdl_mem[paddr[w]];
        else mdl_b_rd = mdl_mem[paddr[w]];
        chk("resp_a_ack",  32'(a_ack), 32'(w == 0));
        chk("resp_b_ack",  32'(b_ack), 32'(w == 1));
        chk("resp_strobe", 32'({ram_we, ram_re}), 32'd0);
        chk("resp_addr",   32'(ram_addr), 32'd0);
        chk("resp_a_rd",   32'(a_rdata), 32'(mdl_a_rd));
        chk("resp_b_rd",   32'(b_rdata), 32'(mdl_b_rd));
        mdl_last_b = (w == 1);
        pv[w] = 1'b0;
        @(posedge clk); #1;
        drive();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack",  32'({a_ack, b_ack}), 32'd0);
        chk("idle_a_rd", 32'(a_rdata), 32'(mdl_a_rd));
        chk("idle_b_rd", 32'(b_rdata), 32'(mdl_b_rd));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("both_acks",    32'(a_ack && b_ack), 32'd0);
            chk("both_strobes", 32'(ram_we && ram_re), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        mdl_last_b = 1'b1; mdl_a_rd = '0; mdl_b_rd = '0;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pwe[p] = 1'b0; paddr[p] = '0; pwd[p] = '0;
        end
        drive();

        // Reset state
        #1 rst = 1'b1; mem_init = 1'b1;
        #1;
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_acks",   32'({a_ack, b_ack}), 32'd0);
        chk("rst_strobe", 32'({ram_we, ram_re}), 32'd0);
        chk("rst_addr",   32'(ram_addr), 32'd0);
        chk("rst_wdata",  32'(ram_wdata), 32'd0);
        chk("rst_rdata",  32'({a_rdata, b_rdata}), 32'd0);
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // A write then read; B write then read (A rdata must hold)
        set_req(0, 1'b1, 8'h00, 8'h55); run_grant();
        set_req(0, 1'b0, 8'h00, 8'h00); run_grant();
        set_req(1, 1'b1, 8'h01, 8'hAA); run_grant();
        set_req(1, 1'b0, 8'h01, 8'h00); run_grant();
        set_req(0, 1'b1, 8'h02, 8'hFF); run_grant();

        // Back-to-back A reads
        set_req(0, 1'b0, 8'h00, 8'h00); run_grant();
        set_req(0, 1'b0, 8'h01, 8'h00); run_grant();
        set_req(0, 1'b0, 8'h02, 8'h00); run_grant();

        // Both ports requesting continuously for four grants
        for (int k = 0; k < 4; k++) begin
            if (!pv[0]) set_req(0, 1'b0, 8'h00, 8'h00);
            if (!pv[1]) set_req(1, 1'b0, 8'h01, 8'h00);
            run_grant();
        end
        pv[0] = 1'b0; pv[1] = 1'b0; drive();
        @(posedge clk); #1;

        // Reset in the middle of a B write to 0x02
        set_req(1, 1'b1, 8'h02, 8'h33); drive();
        @(posedge clk); #1;
        chk("mid_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_we",    32'(ram_we), 32'd0);
        chk("abort_addr",  32'(ram_addr), 32'd0);
        chk("abort_ack",   32'(b_ack), 32'd0);
        chk("abort_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        mdl_a_rd = '0; mdl_b_rd = '0; mdl_last_b = 1'b1;
        pv[1] = 1'b0; drive();
        @(negedge clk);
        chk("abort_ack_hold", 32'(b_ack), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ack",  32'({a_ack, b_ack}), 32'd0);
        @(posedge clk); #1;

        // Contention straight after reset: A must win first
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h02, 8'h00);
        run_grant();
        run_grant();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom_range(0, 1) == 1))
                    set_req(p, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            end
            if (pv[0] || pv[1]) begin
                run_grant();
            end else begin
                drive();
                @(posedge clk); #1;
                chk("rand_idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
